// File: rtl/hyper_titan_pkg.sv
// Shared types and constants for the test-control block: APB structs,
// register offsets, FSM states and CTRL/STATUS bit positions.
package hyper_titan_pkg;

  typedef struct packed {
    logic [11:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
  } apb_req_t;

  typedef struct packed {
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;
  } apb_resp_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_DONE    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_e;

  localparam logic [11:0] ADDR_CTRL   = 12'h000;
  localparam logic [11:0] ADDR_STATUS = 12'h004;
  localparam logic [11:0] ADDR_EOT    = 12'h008;
  localparam logic [11:0] ADDR_TLIMIT = 12'h00C;
  localparam logic [11:0] ADDR_COUNT  = 12'h010;
  localparam logic [11:0] ADDR_MBOX   = 12'h100;

  localparam logic [31:0] TIMEOUT_CODE = 32'hDEAD_0001;

  localparam int CTRL_WD_EN   = 0;
  localparam int CTRL_CLEAR   = 1;
  localparam int STAT_EOT     = 0;
  localparam int STAT_PASS    = 1;
  localparam int STAT_TIMEOUT = 2;
  localparam int STAT_STATE   = 3;

  function automatic logic [31:0] strb_mask(input logic [3:0] strb);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{strb[i]}};
    return m;
  endfunction

endpackage

// File: rtl/hyper_titan_wdt_cnt.sv
// Watchdog counter: counts while enabled, flags expiry when count equals
// the limit, and saturates at all-ones if the limit was moved below it.
module hyper_titan_wdt_cnt #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_enable,
  input  logic         i_clear,
  input  logic [W-1:0] i_limit,
  output logic [W-1:0] o_count,
  output logic         o_expire
);

  logic [W-1:0] r_count;

  assign o_expire = i_enable && (r_count == i_limit);
  assign o_count  = r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_expire && (r_count != '1)) begin
      r_count <= r_count + W'(1);
    end
  end

endmodule

// File: rtl/hyper_titan_test_ctrl.sv
// Test controller: APB register file, mailboxes and end-of-test/watchdog FSM.
// States: IDLE | RUN (watchdog counting) | DONE (EOT seen) | TIMEOUT (expired)
module hyper_titan_test_ctrl
  import hyper_titan_pkg::*;
#(
  parameter int          NUM_MBOX    = 4,
  parameter int          TIMEOUT_W   = 32,
  parameter logic [31:0] DEF_TIMEOUT = 32'd100000
) (
  input  logic                  apb_clk_i,
  input  logic                  apb_arst_ni,
  input  apb_req_t              apb_req_i,
  output apb_resp_t             apb_resp_o,
  output logic                  eot_o,
  output logic                  pass_o,
  output logic                  timeout_o,
  output logic [31:0]           fail_code_o,
  output logic [NUM_MBOX*32-1:0] mbox_o
);

  logic                 w_access, w_mbox_hit, w_err, w_wr;
  logic                 w_sel_ctrl, w_sel_eot, w_sel_tlimit, w_sel_mbox;
  logic [11:0]          w_addr;
  logic [3:0]           w_mbox_idx;
  logic [31:0]          w_rdata, w_mask, w_tlimit_wr, w_status;
  logic                 w_ctrl_wr, w_eot_wr, w_clear, w_run, w_expire;
  logic [TIMEOUT_W-1:0] w_count;

  state_e               r_state, w_state_nxt, w_state_base;
  logic                 r_wd_en, r_eot, r_pass, r_timeout;
  logic [31:0]          r_fail_code;
  logic                 w_eot_nxt, w_pass_nxt, w_timeout_nxt;
  logic [31:0]          w_fail_nxt;
  logic [TIMEOUT_W-1:0] r_tlimit;
  logic [31:0]          r_mbox [NUM_MBOX];

  // Reset also gates the response so the bus sees all zeros while held.
  assign w_access   = apb_req_i.psel && apb_req_i.penable && apb_arst_ni;
  assign w_addr     = apb_req_i.paddr;
  assign w_mbox_idx = w_addr[5:2];
  assign w_mbox_hit = (w_addr[11:6] == ADDR_MBOX[11:6]) &&
                      ({28'd0, w_mbox_idx} < 32'(NUM_MBOX));
  assign w_mask     = strb_mask(apb_req_i.pstrb);

  always_comb begin
    w_status                     = '0;
    w_status[STAT_EOT]           = r_eot;
    w_status[STAT_PASS]          = r_pass;
    w_status[STAT_TIMEOUT]       = r_timeout;
    w_status[STAT_STATE +: 2]    = r_state;
  end

  always_comb begin
    w_err        = 1'b0;
    w_rdata      = '0;
    w_sel_ctrl   = 1'b0;
    w_sel_eot    = 1'b0;
    w_sel_tlimit = 1'b0;
    w_sel_mbox   = 1'b0;
    if (w_access) begin
      if (w_addr[1:0] != 2'b00) begin
        w_err = 1'b1;
      end else if (w_mbox_hit) begin
        w_sel_mbox = 1'b1;
        for (int i = 0; i < NUM_MBOX; i++)
          if (w_mbox_idx == 4'(i)) w_rdata = r_mbox[i];
      end else begin
        case (w_addr)
          ADDR_CTRL: begin
            w_sel_ctrl          = 1'b1;
            w_rdata[CTRL_WD_EN] = r_wd_en;
          end
          ADDR_STATUS: begin
            if (apb_req_i.pwrite) w_err = 1'b1;
            else                  w_rdata = w_status;
          end
          ADDR_EOT: begin
            if (apb_req_i.pwrite) w_sel_eot = 1'b1;
            else                  w_err = 1'b1;
          end
          ADDR_TLIMIT: begin
            w_sel_tlimit = 1'b1;
            w_rdata      = 32'(r_tlimit);
          end
          ADDR_COUNT: begin
            if (apb_req_i.pwrite) w_err = 1'b1;
            else                  w_rdata = 32'(w_count);
          end
          default: w_err = 1'b1;
        endcase
      end
    end
  end

  assign w_wr        = w_access && apb_req_i.pwrite && !w_err;
  assign w_ctrl_wr   = w_wr && w_sel_ctrl;
  assign w_eot_wr    = w_wr && w_sel_eot;
  assign w_clear     = w_ctrl_wr && apb_req_i.pwdata[CTRL_CLEAR];
  assign w_run       = (r_state == ST_RUN);
  assign w_tlimit_wr = (32'(r_tlimit) & ~w_mask) | (apb_req_i.pwdata & w_mask);

  assign apb_resp_o = '{pready: w_access, prdata: w_rdata, pslverr: w_err};

  hyper_titan_wdt_cnt #(.W(TIMEOUT_W)) u_wdt (
    .i_clk    (apb_clk_i),
    .i_rst_n  (apb_arst_ni),
    .i_enable (w_run),
    .i_clear  (w_clear),
    .i_limit  (r_tlimit),
    .o_count  (w_count),
    .o_expire (w_expire)
  );

  // Clear is applied first so a combined clear+wd_en lands in RUN.
  always_comb begin
    w_state_base  = r_state;
    w_eot_nxt     = r_eot;
    w_pass_nxt    = r_pass;
    w_timeout_nxt = r_timeout;
    w_fail_nxt    = r_fail_code;
    if (w_clear) begin
      w_state_base  = ST_IDLE;
      w_eot_nxt     = 1'b0;
      w_pass_nxt    = 1'b0;
      w_timeout_nxt = 1'b0;
      w_fail_nxt    = '0;
    end
    w_state_nxt = w_state_base;
    case (w_state_base)
      ST_IDLE, ST_RUN: begin
        if (w_eot_wr) begin
          w_state_nxt = ST_DONE;
          w_eot_nxt   = 1'b1;
          w_pass_nxt  = (apb_req_i.pwdata == 32'd0);
          w_fail_nxt  = apb_req_i.pwdata;
        end else if (w_ctrl_wr && (w_state_base == ST_IDLE)) begin
          if (apb_req_i.pwdata[CTRL_WD_EN]) w_state_nxt = ST_RUN;
        end else if (w_ctrl_wr) begin
          if (!apb_req_i.pwdata[CTRL_WD_EN]) w_state_nxt = ST_IDLE;
        end else if (w_expire) begin
          w_state_nxt   = ST_TIMEOUT;
          w_eot_nxt     = 1'b1;
          w_pass_nxt    = 1'b0;
          w_timeout_nxt = 1'b1;
          w_fail_nxt    = TIMEOUT_CODE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge apb_clk_i or negedge apb_arst_ni) begin
    if (!apb_arst_ni) begin
      r_state     <= ST_IDLE;
      r_eot       <= 1'b0;
      r_pass      <= 1'b0;
      r_timeout   <= 1'b0;
      r_fail_code <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_eot       <= w_eot_nxt;
      r_pass      <= w_pass_nxt;
      r_timeout   <= w_timeout_nxt;
      r_fail_code <= w_fail_nxt;
    end
  end

  always_ff @(posedge apb_clk_i or negedge apb_arst_ni) begin
    if (!apb_arst_ni) begin
      r_wd_en  <= 1'b0;
      r_tlimit <= DEF_TIMEOUT[TIMEOUT_W-1:0];
      for (int i = 0; i < NUM_MBOX; i++) r_mbox[i] <= '0;
    end else begin
      if (w_ctrl_wr) r_wd_en <= apb_req_i.pwdata[CTRL_WD_EN];
      if (w_wr && w_sel_tlimit) r_tlimit <= w_tlimit_wr[TIMEOUT_W-1:0];
      for (int i = 0; i < NUM_MBOX; i++)
        if (w_wr && w_sel_mbox && (w_mbox_idx == 4'(i)))
          r_mbox[i] <= (r_mbox[i] & ~w_mask) | (apb_req_i.pwdata & w_mask);
    end
  end

  assign eot_o       = r_eot;
  assign pass_o      = r_pass;
  assign timeout_o   = r_timeout;
  assign fail_code_o = r_fail_code;

  for (genvar g = 0; g < NUM_MBOX; g++) begin : g_mbox
    assign mbox_o[32*g +: 32] = r_mbox[g];
  end

endmodule

// File: tb/tb_hyper_titan_test_ctrl.sv
// Self-checking bench for hyper_titan_test_ctrl: APB register traffic,
// watchdog timing, EOT handling and asynchronous reset.
module tb_hyper_titan_test_ctrl;
  import hyper_titan_pkg::*;

  localparam int NM = 4;
  localparam logic [31:0] DEF_TO = 32'd100000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  apb_req_t  req;
  apb_resp_t resp;
  logic eot, pass, tmo;
  logic [31:0] fail;
  logic [NM*32-1:0] mbox;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] g_rdata;
  logic g_err, g_rdy_setup, g_rdy_acc;
  logic [31:0] m_mbox [NM];
  logic [31:0] m_tlimit;

  always #5 clk = ~clk;

  hyper_titan_test_ctrl #(.NUM_MBOX(NM), .TIMEOUT_W(32), .DEF_TIMEOUT(DEF_TO)) dut (
    .apb_clk_i   (clk),
    .apb_arst_ni (rst_n),
    .apb_req_i   (req),
    .apb_resp_o  (resp),
    .eot_o       (eot),
    .pass_o      (pass),
    .timeout_o   (tmo),
    .fail_code_o (fail),
    .mbox_o      (mbox)
  );

  function automatic logic [31:0] bmask(input logic [3:0] s);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = s[i] ? 8'hFF : 8'h00;
    return m;
  endfunction

  // One full APB transfer; the third posedge inside is the access edge.
  task automatic apb(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                     input logic [3:0] strb);
    @(posedge clk); #1;
    req.paddr = addr[11:0]; req.psel = 1'b1; req.penable = 1'b0;
    req.pwrite = wr; req.pwdata = wdata; req.pstrb = strb;
    #2 g_rdy_setup = resp.pready;
    @(posedge clk); #1;
    req.penable = 1'b1;
    #2;
    g_rdata = resp.prdata; g_err = resp.pslverr; g_rdy_acc = resp.pready;
    @(posedge clk); #1;
    req.psel = 1'b0; req.penable = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_cmp++; if ({eot, pass, tmo} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {eot, pass, tmo}); end
    n_cmp++; if (fail !== 32'd0) begin n_err++; $display("FAIL reset_fail_code: got %h want 0", fail); end
    n_cmp++; if (mbox !== '0) begin n_err++; $display("FAIL reset_mbox: got %h want 0", mbox); end
    n_cmp++; if (resp !== '0) begin n_err++; $display("FAIL reset_resp: got %h want 0", resp); end
    apb(32'h004, 1'b0, 32'd0, 4'hF);
    n_cmp++; if (g_rdata !== 32'd0) begin n_err++; $display("FAIL reset_status: got %h want 0", g_rdata); end
    apb(32'h00C, 1'b0, 32'd0, 4'hF);
    n_cmp++; if (g_rdata !== DEF_TO) begin n_err++; $display("FAIL reset_tlimit: got %h want %h", g_rdata, DEF_TO); end
    apb(32'h010, 1'b0, 32'd0, 4'hF);
    n_cmp++; if (g_rdata !== 32'd0) begin n_err++; $display("FAIL reset_count: got %h want 0", g_rdata); end
  endtask

  // Random traffic in IDLE; the model is the register map as plain arrays.
  task automatic test_random_regs();
    for (int t = 0; t < 60; t++) begin
      int sel, idx;
      logic [31:0] a, d, exp_rd;
      logic wr, exp_err;
      logic [3:0] s;
      sel = int'($urandom_range(0, 6)); idx = 0;
      d = $urandom; s = 4'($urandom_range(0, 15)); wr = 1'($urandom_range(0, 1));
      exp_err = 1'b0; exp_rd = 32'd0; a = 32'd0;
      case (sel)
        0: begin
          idx = int'($urandom_range(0, 7));
          a = 32'h100 + 32'(4 * idx);
          if (idx >= NM) exp_err = 1'b1; else exp_rd = m_mbox[idx];
        end
        1: begin a = 32'h00C; exp_rd = m_tlimit; end
        2: begin a = 32'h004; exp_err = wr; end
        3: begin a = 32'h010; exp_err = wr; end
        4: begin a = 32'h100 + 32'($urandom_range(1, 3)); exp_err = 1'b1; end
        5: begin
          case ($urandom_range(0, 3))
            0: a = 32'h014;
            1: a = 32'h0FC;
            2: a = 32'h140;
            default: a = 32'h800;
          endcase
          exp_err = 1'b1;
        end
        default: begin a = 32'h000; wr = 1'b0; end
      endcase
      apb(a, wr, d, s);
      n_cmp++; if (g_err !== exp_err) begin n_err++; $display("FAIL rand_err[%0d] addr=%h wr=%b: got %b want %b", t, a, wr, g_err, exp_err); end
      if (!wr) begin
        n_cmp++; if (g_rdata !== exp_rd) begin n_err++; $display("FAIL rand_rdata[%0d] addr=%h: got %h want %h", t, a, g_rdata, exp_rd); end
      end
      if (wr && !exp_err) begin
        if (sel == 0) m_mbox[idx] = (m_mbox[idx] & ~bmask(s)) | (d & bmask(s));
        if (sel == 1) m_tlimit = (m_tlimit & ~bmask(s)) | (d & bmask(s));
      end
    end
    for (int i = 0; i < NM; i++) begin
      n_cmp++; if (mbox[32*i +: 32] !== m_mbox[i]) begin n_err++; $display("FAIL rand_mbox_o[%0d]: got %h want %h", i, mbox[32*i +: 32], m_mbox[i]); end
    end
  endtask

  task automatic test_mbox_strobe();
    apb(32'h108, 1'b1, 32'd0, 4'hF);
    apb(32'h108, 1'b1, 32'hA5A5_1234, 4'b0011);
    n_cmp++; if (g_err !== 1'b0) begin n_err++; $display("FAIL strb_wr_err: got %b want 0", g_err); end
    n_cmp++; if ({g_rdy_setup, g_rdy_acc} !== 2'b01) begin n_err++; $display("FAIL strb_pready: got %b want 01", {g_rdy_setup, g_rdy_acc}); end
    apb(32'h108, 1'b0, 32'd0, 4'hF);
    m_mbox[2] = 32'h0000_1234;
    n_cmp++; if (g_rdata !== 32'h0000_1234) begin n_err++; $display("FAIL strb_rdata: got %h want 00001234", g_rdata); end
    n_cmp++; if (g_err !== 1'b0) begin n_err++; $display("FAIL strb_rd_err: got %b want 0", g_err); end
  endtask

  task automatic test_setup_no_effect();
    @(posedge clk); #1;
    req.paddr = 12'h100; req.psel = 1'b1; req.penable = 1'b0;
    req.pwrite = 1'b1; req.pwdata = ~m_mbox[0]; req.pstrb = 4'hF;
    #2;
    n_cmp++; if (resp !== '0) begin n_err++; $display("FAIL setup_resp: got %h want 0", resp); end
    @(posedge clk); #1;
    req.psel = 1'b0;
    idle(2);
    apb(32'h100, 1'b0, 32'd0, 4'hF);
    n_cmp++; if (g_rdata !== m_mbox[0]) begin n_err++; $display("FAIL setup_mbox0: got %h want %h", g_rdata, m_mbox[0]); end
  endtask

  task automatic test_errors();
    logic [31:0] ea [5];
    logic        ew [5];
    ea = '{32'h014, 32'h004, 32'h008, 32'h010, 32'h10A};
    ew = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      apb(ea[i], ew[i], 32'hFFFF_FFFF, 4'hF);
      n_cmp++; if ({g_rdy_acc, g_err, g_rdata} !== {2'b11, 32'd0}) begin n_err++; $display("FAIL err_resp[%0d] addr=%h: got rdy=%b err=%b rd=%h want 1 1 0", i, ea[i], g_rdy_acc, g_err, g_rdata); end
    end
    apb(32'h004, 1'b0, 32'd0, 4'hF);
    n_cmp++; if (g_rdata !== 32'd0) begin n_err++; $display("FAIL err_status_kept: got %h want 0", g_rdata); end
    apb(32'h108, 1'b0, 32'd0, 4'hF);
    n_cmp++; if (g_rdata !== m_mbox[2]) begin n_err++; $display("FAIL err_mbox_kept: got %h want %h", g_rdata, m_mbox[2]); end
  endtask

  task automatic test_timeout();
    int rise_t, rise_e;
    rise_t = -1; rise_e = -1;
    apb(32'h000, 1'b1, 32'h2, 4'hF);
    apb(32'h00C, 1'b1, 32'd10, 4'hF);
    apb(32'h000, 1'b1, 32'h1, 4'hF);
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (tmo && rise_t < 0) rise_t = k;
      if (eot && rise_e < 0) rise_e = k;
    end
    n_cmp++; if (rise_t != 11) begin n_err++; $display("FAIL to_rise_cycle: got %0d want 11", rise_t); end
    n_cmp++; if (rise_e != 11) begin n_err++; $display("FAIL to_eot_cycle: got %0d want 11", rise_e); end
    n_cmp++; if (fail !== 32'hDEAD_0001) begin n_err++; $display("FAIL to_fail_code: got %h want dead0001", fail); end
    apb(32'h004, 1'b0, 32'd0, 4'hF);
    n_cmp++; if (g_rdata !== 32'h1D) begin n_err++; $display("FAIL to_status: got %h want 0000001d", g_rdata); end
    apb(32'h008, 1'b1, 32'd5, 4'hF);
    n_cmp++; if ({g_err, fail} !== {1'b0, 32'hDEAD_0001}) begin n_err++; $display("FAIL to_eot_ignored: err=%b fail=%h want 0 dead0001", g_err, fail); end
    apb(32'h000, 1'b1, 32'h2, 4'hF);
    n_cmp++; if ({eot, pass, tmo, fail} !== 35'd0) begin n_err++; $display("FAIL clr_outputs: got %b %h want 0", {eot, pass, tmo}, fail); end
    apb(32'h010, 1'b0, 32'd0, 4'hF);
    n_cmp++; if (g_rdata !== 32'd0) begin n_err++; $display("FAIL clr_count: got %h want 0", g_rdata); end
    apb(32'h00C, 1'b0, 32'd0, 4'hF);
    n_cmp++; if (g_rdata !== 32'd10) begin n_err++; $display("FAIL clr_tlimit_kept: got %h want 0000000a", g_rdata); end
    n_cmp++; if (mbox[64 +: 32] !== m_mbox[2]) begin n_err++; $display("FAIL clr_mbox_kept: got %h want %h", mbox[64 +: 32], m_mbox[2]); end
  endtask

  task automatic test_pass();
    apb(32'h00C, 1'b1, 32'd1000, 4'hF);
    apb(32'h000, 1'b1, 32'h1, 4'h0);
    apb(32'h004, 1'b0, 32'd0, 4'hF);
    n_cmp++; if (g_rdata !== 32'h08) begin n_err++; $display("FAIL pass_run_state: got %h want 00000008", g_rdata); end
    apb(32'h008, 1'b1, 32'd0, 4'h0);
    n_cmp++; if ({eot, pass, tmo, fail} !== {3'b110, 32'd0}) begin n_err++; $display("FAIL pass_eot0: got %b %h want 110 0", {eot, pass, tmo}, fail); end
    apb(32'h008, 1'b1, 32'd7, 4'hF);
    n_cmp++; if ({pass, fail} !== {1'b1, 32'd0}) begin n_err++; $display("FAIL pass_sticky: got pass=%b fail=%h want 1 0", pass, fail); end
    apb(32'h004, 1'b0, 32'd0, 4'hF);
    n_cmp++; if (g_rdata !== 32'h13) begin n_err++; $display("FAIL pass_status: got %h want 00000013", g_rdata); end
  endtask

  task automatic test_count_read();
    int n;
    n = 0;
    for (int it = 0; it < 3; it++) begin
      n = int'($urandom_range(0, 5));
      apb(32'h000, 1'b1, 32'h3, 4'hF);
      idle(n);
      apb(32'h010, 1'b0, 32'd0, 4'hF);
      n_cmp++; if (g_rdata !== 32'(n + 2)) begin n_err++; $display("FAIL count_run[%0d]: got %0d want %0d", it, g_rdata, n + 2); end
    end
    apb(32'h000, 1'b1, 32'h0, 4'hF);
    apb(32'h010, 1'b0, 32'd0, 4'hF);
    n_cmp++; if (g_rdata !== 32'(n + 6)) begin n_err++; $display("FAIL count_stop: got %0d want %0d", g_rdata, n + 6); end
    idle(3);
    apb(32'h010, 1'b0, 32'd0, 4'hF);
    n_cmp++; if (g_rdata !== 32'(n + 6)) begin n_err++; $display("FAIL count_hold_idle: got %0d want %0d", g_rdata, n + 6); end
    apb(32'h004, 1'b0, 32'd0, 4'hF);
    n_cmp++; if (g_rdata !== 32'd0) begin n_err++; $display("FAIL count_idle_status: got %h want 0", g_rdata); end
  endtask

  task automatic test_eot_race();
    apb(32'h00C, 1'b1, 32'd10, 4'hF);
    apb(32'h000, 1'b1, 32'h3, 4'hF);
    idle(8);
    apb(32'h008, 1'b1, 32'h42, 4'hF);
    n_cmp++; if ({eot, pass, tmo, fail} !== {3'b100, 32'h42}) begin n_err++; $display("FAIL race_outputs: got %b %h want 100 00000042", {eot, pass, tmo}, fail); end
    idle(5);
    apb(32'h004, 1'b0, 32'd0, 4'hF);
    n_cmp++; if (g_rdata !== 32'h11) begin n_err++; $display("FAIL race_status: got %h want 00000011", g_rdata); end
  endtask

  task automatic test_tlimit_change();
    int w, d, rise;
    apb(32'h00C, 1'b1, 32'd1000, 4'hF);
    apb(32'h000, 1'b1, 32'h3, 4'hF);
    n_cmp++; if ({eot, pass, tmo, fail} !== 35'd0) begin n_err++; $display("FAIL clrrun_outputs: got %b %h want 0", {eot, pass, tmo}, fail); end
    apb(32'h004, 1'b0, 32'd0, 4'hF);
    n_cmp++; if (g_rdata !== 32'h08) begin n_err++; $display("FAIL clrrun_status: got %h want 00000008", g_rdata); end
    for (int it = 0; it < 3; it++) begin
      w = int'($urandom_range(0, 4)); d = int'($urandom_range(0, 3)); rise = -1;
      apb(32'h000, 1'b1, 32'h3, 4'hF);
      idle(w);
      apb(32'h00C, 1'b1, 32'(w + 3 + d), 4'hF);
      for (int k = 1; k <= 10; k++) begin
        @(posedge clk); #1;
        if (tmo && rise < 0) rise = k;
      end
      n_cmp++; if (rise != d + 1) begin n_err++; $display("FAIL tlimit_live[%0d]: got %0d want %0d", it, rise, d + 1); end
    end
    apb(32'h000, 1'b1, 32'h2, 4'hF);
    apb(32'h00C, 1'b1, 32'd0, 4'hF);
    apb(32'h000, 1'b1, 32'h1, 4'hF);
    n_cmp++; if (tmo !== 1'b0) begin n_err++; $display("FAIL tlimit0_early: got %b want 0", tmo); end
    @(posedge clk); #1;
    n_cmp++; if ({tmo, fail} !== {1'b1, 32'hDEAD_0001}) begin n_err++; $display("FAIL tlimit0_first: got %b %h want 1 dead0001", tmo, fail); end
  endtask

  task automatic test_reset_midrun();
    apb(32'h000, 1'b1, 32'h2, 4'hF);
    apb(32'h00C, 1'b1, 32'd1000, 4'hF);
    apb(32'h108, 1'b1, 32'hCAFE_F00D, 4'hF);
    apb(32'h000, 1'b1, 32'h1, 4'hF);
    idle(5);
    req.paddr = 12'h00C; req.psel = 1'b1; req.penable = 1'b1; req.pwrite = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if ({eot, pass, tmo, fail, mbox} !== '0) begin n_err++; $display("FAIL arst_outputs: got %b %h %h want 0", {eot, pass, tmo}, fail, mbox); end
    n_cmp++; if (resp !== '0) begin n_err++; $display("FAIL arst_resp: got %h want 0", resp); end
    req.psel = 1'b0; req.penable = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    apb(32'h00C, 1'b0, 32'd0, 4'hF);
    n_cmp++; if (g_rdata !== DEF_TO) begin n_err++; $display("FAIL arst_tlimit: got %h want %h", g_rdata, DEF_TO); end
    apb(32'h010, 1'b0, 32'd0, 4'hF);
    n_cmp++; if (g_rdata !== 32'd0) begin n_err++; $display("FAIL arst_count: got %h want 0", g_rdata); end
    apb(32'h004, 1'b0, 32'd0, 4'hF);
    n_cmp++; if (g_rdata !== 32'd0) begin n_err++; $display("FAIL arst_status: got %h want 0", g_rdata); end
  endtask

  initial begin
    #400000;
    $display("FAIL sim_time_limit: bench did not finish, want finish before 400000");
    $fatal(1);
  end

  initial begin
    req = '0;
    for (int i = 0; i < NM; i++) m_mbox[i] = 32'd0;
    m_tlimit = DEF_TO;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_random_regs();
    test_mbox_strobe();
    test_setup_no_effect();
    test_errors();
    test_timeout();
    test_pass();
    test_count_read();
    test_eot_race();
    test_tlimit_change();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
